lutram_fifo: RTL
================

Name: lutram_fifo

Overview:
- Parametrised synchronous FIFO built on distributed (LUT) RAM, first-word-fall-through (FWFT).
- Generalises the 32x1 single-port select RAM to WIDTH bits by 2**DEPTH_LOG2 entries.
- Has separate write and read addresses, pointer management, full/empty flags and an occupancy count.
- Used as a small elastic buffer between pipeline stages in Verilator-simulated Xilinx designs.

Parameters:
- WIDTH, 8: data word width in bits (1..64).
- DEPTH_LOG2, 5: log2 of the entry count; depth = 2**DEPTH_LOG2 (2..8, i.e. 4..256 entries).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- WR_EN  input  1  write request.
- WR_DATA  input  WIDTH  write data.
- FULL  output  1  FIFO holds 2**DEPTH_LOG2 entries.
- RD_EN  input  1  read (pop) request.
- RD_DATA  output  WIDTH  head-of-FIFO data (FWFT), valid when EMPTY=0.
- EMPTY  output  1  FIFO holds 0 entries.
- LEVEL  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- OVERFLOW  output  1  sticky write-when-full error; see Optional Feature.
- UNDERFLOW  output  1  sticky read-when-empty error; see Optional Feature.

Behaviour:
- Reset: one clock, CLK; reset RST is asynchronous and active-high.
  - On RST assertion: write/read pointers=0, LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0, immediately and without waiting for a clock edge.
  - Memory contents are NOT reset. Power-up contents are all zero.
  - Reset mid-operation discards all stored entries.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits; the low DEPTH_LOG2 bits address the RAM and the MSB is the wrap bit.
  - Both increment modulo 2**(DEPTH_LOG2+1).
- Flags and level:
  - EMPTY = (wr_ptr == rd_ptr).
  - FULL = (low bits equal) and (MSBs differ).
  - LEVEL = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
  - All three are registered or derived from registered pointers only; no combinational path from WR_EN/RD_EN.
- Write: accepted iff WR_EN=1 and FULL=0.
  - On the accepting edge, mem[wr_ptr low bits] <= WR_DATA and wr_ptr increments.
- Read: accepted iff RD_EN=1 and EMPTY=0.
  - rd_ptr increments on the accepting edge.
- RD_DATA timing:
  - RD_DATA = mem[rd_ptr low bits], an asynchronous read with zero latency.
  - A word written into an empty FIFO appears on RD_DATA, with EMPTY=0, in the cycle after the write edge.
  - RD_DATA is don't-care while EMPTY=1.
- Simultaneous write and read:
  - Not full and not empty: both accepted; LEVEL unchanged.
  - FULL=1: only the read is accepted; the write is dropped; LEVEL decrements.
  - EMPTY=1: only the write is accepted (no bypass); LEVEL increments.
- Rejected requests leave all state unchanged.
- Wrap-around: pointer low bits roll from 2**DEPTH_LOG2-1 to 0 transparently; data order is preserved.

Optional Feature:
- Macro: LUTRAM_FIFO_ERR_EN.
- Defined:
  - OVERFLOW sets on any edge with WR_EN=1 and FULL=1.
  - UNDERFLOW sets on any edge with RD_EN=1 and EMPTY=1.
  - Both flags are sticky until RST.
- Undefined: OVERFLOW and UNDERFLOW are tied to 0 and no error logic is compiled. The port list is identical in both builds.

Decomposition:
- Package lutram_pkg:
  - localparam helpers: depth from DEPTH_LOG2, pointer width.
  - A function computing LEVEL from two pointers.
  - Parameter range checks done via a static assertion function.
- Sub-module lutram_sdp: simple dual-port distributed RAM.
  - Parametrised WIDTH/DEPTH_LOG2.
  - Synchronous write (CLK, WE, WA, D) and asynchronous read (RA, O).
  - Zero power-up init; no reset.
- lutram_fifo instantiates one lutram_sdp plus the pointer/flag logic.

Test Plan:
- Reset then idle, WIDTH=8, DEPTH_LOG2=2 -> EMPTY=1, FULL=0, LEVEL=0, OVERFLOW=UNDERFLOW=0.
- Write 0x11,0x22,0x33,0x44 on 4 consecutive edges -> FULL=1, LEVEL=4.
  - A fifth write of 0x55 is dropped.
  - Draining reads 0x11,0x22,0x33,0x44 in order, then EMPTY=1.
  - With LUTRAM_FIFO_ERR_EN, OVERFLOW=1 after the fifth write.
- Write 0xA5 into an empty FIFO -> next cycle EMPTY=0, RD_DATA=0xA5, LEVEL=1.
  - WR_EN and RD_EN together on that write edge leave RD_EN ignored.
- Steady state, LEVEL=2, WR_EN=RD_EN=1 for 10 cycles, data 0x00..0x09 -> LEVEL stays 2.
  - Output order is continuous across pointer wrap (pointers pass index 3->0 at least twice).
- Full FIFO, WR_EN=RD_EN=1 -> LEVEL 4->3, FULL=0, write data absent from later reads.
  - RD_EN on an empty FIFO with LUTRAM_FIFO_ERR_EN -> UNDERFLOW=1, pointers unchanged.
- Assert RST asynchronously mid-cycle with LEVEL=3 -> EMPTY=1 and LEVEL=0 before the next CLK edge.
  - A subsequent write of 0x7E reads back 0x7E.

Source files
------------

// File: rtl/lutram_pkg.sv
// -----------------------------------------------------------------------------
// lutram_pkg
// Shared helpers for the LUT-RAM FIFO slice:
//   - depth and pointer-width helpers derived from DEPTH_LOG2
//   - occupancy computation from a write/read pointer pair
//   - parameter range check used at elaboration time
// No ports (package).
// -----------------------------------------------------------------------------
package lutram_pkg;

  localparam int unsigned MIN_WIDTH      = 1;
  localparam int unsigned MAX_WIDTH      = 64;
  localparam int unsigned MIN_DEPTH_LOG2 = 2;
  localparam int unsigned MAX_DEPTH_LOG2 = 8;

  // Widest pointer any legal configuration can need (wrap bit included).
  localparam int unsigned MAX_PTR_W = MAX_DEPTH_LOG2 + 1;

  function automatic int unsigned depth_of(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int unsigned ptr_w_of(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  // Occupancy = (wr - rd) mod 2**ptr_w. Operands are zero-extended to the
  // widest pointer; masking afterwards restores the modulus of the real width.
  function automatic logic [MAX_PTR_W-1:0] level_of(
    input logic [MAX_PTR_W-1:0] wr,
    input logic [MAX_PTR_W-1:0] rd,
    input int unsigned          ptr_w
  );
    logic [MAX_PTR_W-1:0] mask;
    mask = MAX_PTR_W'((32'd1 << ptr_w) - 32'd1);
    return (wr - rd) & mask;
  endfunction

  function automatic bit params_ok(
    input int unsigned width,
    input int unsigned depth_log2
  );
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           (depth_log2 >= MIN_DEPTH_LOG2) && (depth_log2 <= MAX_DEPTH_LOG2);
  endfunction

endpackage

// File: rtl/lutram_sdp.sv
// -----------------------------------------------------------------------------
// lutram_sdp
// Simple dual-port distributed RAM, WIDTH bits x 2**DEPTH_LOG2 entries.
// Synchronous write port, asynchronous (zero-latency) read port. Contents
// power up as zero and are never reset.
// Ports:
//   CLK  in   write clock
//   WE   in   write enable
//   WA   in   write address  [DEPTH_LOG2-1:0]
//   D    in   write data     [WIDTH-1:0]
//   RA   in   read address   [DEPTH_LOG2-1:0]
//   O    out  read data      [WIDTH-1:0] = mem[RA], combinational
// -----------------------------------------------------------------------------
module lutram_sdp
  import lutram_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  CLK,
  input  logic                  WE,
  input  logic [DEPTH_LOG2-1:0] WA,
  input  logic [WIDTH-1:0]      D,
  input  logic [DEPTH_LOG2-1:0] RA,
  output logic [WIDTH-1:0]      O
);

  localparam int unsigned DEPTH = depth_of(DEPTH_LOG2);

  // Declaration initialiser gives the all-zero power-up image that LUT RAM
  // provides after configuration.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[WA] <= D;
    end
  end

  assign O = mem[RA];

endmodule

// File: rtl/lutram_fifo.sv
// -----------------------------------------------------------------------------
// lutram_fifo
// First-word-fall-through synchronous FIFO on distributed RAM,
// WIDTH bits x 2**DEPTH_LOG2 entries.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous, active-high reset (pointers and flags only)
//   WR_EN      in   write request, accepted when FULL=0
//   WR_DATA    in   write data [WIDTH-1:0]
//   FULL       out  FIFO holds 2**DEPTH_LOG2 entries
//   RD_EN      in   pop request, accepted when EMPTY=0
//   RD_DATA    out  head-of-FIFO word, valid while EMPTY=0
//   EMPTY      out  FIFO holds no entries
//   LEVEL      out  occupancy [DEPTH_LOG2:0]
//   OVERFLOW   out  sticky write-while-full error
//   UNDERFLOW  out  sticky read-while-empty error
// Build option:
//   LUTRAM_FIFO_ERR_EN  when defined, OVERFLOW/UNDERFLOW are live sticky
//                       flags cleared only by RST; otherwise both are tied 0.
// -----------------------------------------------------------------------------
module lutram_fifo
  import lutram_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [WIDTH-1:0]      WR_DATA,
  output logic                  FULL,
  input  logic                  RD_EN,
  output logic [WIDTH-1:0]      RD_DATA,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned PTR_W = ptr_w_of(DEPTH_LOG2);

  if (!params_ok(WIDTH, DEPTH_LOG2)) begin : g_bad_params
    $error("lutram_fifo: WIDTH must be 1..64 and DEPTH_LOG2 2..8");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags and level depend on registered pointers only, so there is no
  // combinational path from the request inputs to any status output.
  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2]     != rd_ptr[DEPTH_LOG2]);
  assign LEVEL = PTR_W'(level_of(MAX_PTR_W'(wr_ptr), MAX_PTR_W'(rd_ptr), PTR_W));

  // Reads gate on EMPTY before this edge's write lands, so a word written
  // into an empty FIFO can never be popped in the same cycle (no bypass).
  assign wr_ok = WR_EN && !FULL;
  assign rd_ok = RD_EN && !EMPTY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  lutram_sdp #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .CLK (CLK),
    .WE  (wr_ok),
    .WA  (wr_ptr[DEPTH_LOG2-1:0]),
    .D   (WR_DATA),
    .RA  (rd_ptr[DEPTH_LOG2-1:0]),
    .O   (RD_DATA)
  );

`ifdef LUTRAM_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (WR_EN && FULL) begin
        ovf_q <= 1'b1;
      end
      if (RD_EN && EMPTY) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule
